// File: rtl/riscv_muldiv_pkg.sv
// riscv_muldiv_pkg: shared constants for the EX-stage multiply/divide unit.
// Funct3 codes, FSM state encoding and the iteration count.
package riscv_muldiv_pkg;

    localparam int XLEN   = 32;
    localparam int N_ITER = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: EX-stage request/response bundle for the muldiv unit.
// master = pipeline side, slave = muldiv unit.
interface ex_muldiv_unit_if;
    import riscv_muldiv_pkg::*;

    logic            Start;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            Flush;
    logic            Stall;
    logic            Done;
    logic [XLEN-1:0] Result;

    modport master (
        output Start, Funct3, SrcA, SrcB, Flush,
        input  Stall, Done, Result
    );

    modport slave (
        input  Start, Funct3, SrcA, SrcB, Flush,
        output Stall, Done, Result
    );

endinterface

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: two-lane conditional two's-complement negate.
// Used for operand magnitudes before the op and result signs after it.
module muldiv_sign_fix #(
    parameter int WA = 32,
    parameter int WB = 32
)(
    input  logic [WA-1:0] i_a,
    input  logic          i_neg_a,
    input  logic [WB-1:0] i_b,
    input  logic          i_neg_b,
    output logic [WA-1:0] o_a,
    output logic [WB-1:0] o_b
);
    assign o_a = i_neg_a ? -i_a : i_a;
    assign o_b = i_neg_b ? -i_b : i_b;
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// Define FAST_MUL_EN for a single-cycle multiplier; divides stay iterative.
module ex_muldiv_unit
    import riscv_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
)(
    input  logic            CLK,
    input  logic            RESET,
    ex_muldiv_unit_if.slave bus
);
    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_f3;
    logic               r_sa;
    logic               r_sb;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_result;

    logic               w_div, w_sgn_a, w_sgn_b;
    logic               w_dz, w_ovf, w_fast;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH-1:0]   w_fast_q, w_fast_rem;
    logic [2*WIDTH-1:0] w_fast_prod;
    logic [WIDTH:0]     w_madd, w_shift, w_trial;
    logic [2*WIDTH-1:0] w_fix_q;
    logic [WIDTH-1:0]   w_fix_r, w_final;
    logic               w_done, w_is_mul;

    assign w_div   = bus.Funct3[2];
    assign w_sgn_a = (bus.Funct3 == F3_MULH) || (bus.Funct3 == F3_MULHSU)
                  || (bus.Funct3 == F3_DIV)  || (bus.Funct3 == F3_REM);
    assign w_sgn_b = (bus.Funct3 == F3_MULH) || (bus.Funct3 == F3_DIV)
                  || (bus.Funct3 == F3_REM);

    muldiv_sign_fix #(.WA(WIDTH), .WB(WIDTH)) u_pre (
        .i_a     (bus.SrcA),
        .i_neg_a (w_sgn_a && bus.SrcA[WIDTH-1]),
        .i_b     (bus.SrcB),
        .i_neg_b (w_sgn_b && bus.SrcB[WIDTH-1]),
        .o_a     (w_mag_a),
        .o_b     (w_mag_b)
    );

    assign w_dz  = w_div && (bus.SrcB == '0);
    assign w_ovf = ((bus.Funct3 == F3_DIV) || (bus.Funct3 == F3_REM))
                && (bus.SrcA == {1'b1, {(WIDTH-1){1'b0}}})
                && (bus.SrcB == '1);

    // Fast results are stored pre-signed; signs are cleared on that path.
    assign w_fast_q   = w_dz ? '1 : {1'b1, {(WIDTH-1){1'b0}}};
    assign w_fast_rem = w_dz ? bus.SrcA : '0;

`ifdef FAST_MUL_EN
    logic signed [2*WIDTH+1:0] w_mprod;
    assign w_mprod = $signed({w_sgn_a & bus.SrcA[WIDTH-1], bus.SrcA})
                   * $signed({w_sgn_b & bus.SrcB[WIDTH-1], bus.SrcB});
    assign w_fast      = w_dz || w_ovf || !w_div;
    assign w_fast_prod = w_div ? {{WIDTH{1'b0}}, w_fast_q}
                               : w_mprod[2*WIDTH-1:0];
`else
    assign w_fast      = w_dz || w_ovf;
    assign w_fast_prod = {{WIDTH{1'b0}}, w_fast_q};
`endif

    assign w_madd  = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                   + (r_prod[0] ? {1'b0, r_opb} : '0);
    assign w_shift = {r_rem, r_prod[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_opb};

    assign w_is_mul = !r_f3[2];

    muldiv_sign_fix #(.WA(2*WIDTH), .WB(WIDTH)) u_post (
        .i_a     (w_is_mul ? r_prod
                           : {{WIDTH{1'b0}}, r_prod[WIDTH-1:0]}),
        .i_neg_a (r_sa ^ r_sb),
        .i_b     (r_rem),
        .i_neg_b (r_sa),
        .o_a     (w_fix_q),
        .o_b     (w_fix_r)
    );

    always_comb begin
        w_final = w_fix_q[WIDTH-1:0];
        unique case (1'b1)
            (r_f3 == F3_MUL):
                w_final = w_fix_q[WIDTH-1:0];
            (!r_f3[2] && (r_f3 != F3_MUL)):
                w_final = w_fix_q[2*WIDTH-1:WIDTH];
            (r_f3[2] && !r_f3[1]):
                w_final = w_fix_q[WIDTH-1:0];
            (r_f3[2] && r_f3[1]):
                w_final = w_fix_r;
        endcase
    end

    assign w_done     = (r_state == S_DONE) && !bus.Flush;
    assign bus.Done   = w_done;
    assign bus.Result = w_done ? w_final : r_result;
    assign bus.Stall  = RESET && !bus.Flush
                     && (((r_state == S_IDLE) && bus.Start)
                      || (r_state == S_CALC));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_f3     <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_prod   <= '0;
            r_rem    <= '0;
            r_opb    <= '0;
            r_result <= '0;
        end else if (bus.Flush) begin
            r_state <= S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_f3  <= bus.Funct3;
                        r_opb <= w_mag_b;
                        if (w_fast) begin
                            r_sa    <= 1'b0;
                            r_sb    <= 1'b0;
                            r_prod  <= w_fast_prod;
                            r_rem   <= w_fast_rem;
                            r_state <= S_DONE;
                        end else begin
                            r_sa    <= w_sgn_a && bus.SrcA[WIDTH-1];
                            r_sb    <= w_sgn_b && bus.SrcB[WIDTH-1];
                            r_prod  <= {{WIDTH{1'b0}}, w_mag_a};
                            r_rem   <= '0;
                            r_cnt   <= CNT_W'(N_ITER - 1);
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (r_f3[2]) begin
                        if (!w_trial[WIDTH]) begin
                            r_rem  <= w_trial[WIDTH-1:0];
                            r_prod <= {r_prod[2*WIDTH-1:WIDTH],
                                       r_prod[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem  <= w_shift[WIDTH-1:0];
                            r_prod <= {r_prod[2*WIDTH-1:WIDTH],
                                       r_prod[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_prod <= {w_madd, r_prod[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0)
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_result <= w_final;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed and random checks of ex_muldiv_unit
// against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;
    import riscv_muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   errs    = 0;
    int   cyc     = 0;

    ex_muldiv_unit_if bus();

    ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        r  = '0;
        case (f3)
            F3_MUL:    begin p = sa * sb; r = p[31:0];  end
            F3_MULH:   begin p = sa * sb; r = p[63:32]; end
            F3_MULHSU: begin p = sa * ub; r = p[63:32]; end
            F3_MULHU:  begin p = ua * ub; r = p[63:32]; end
            F3_DIV:  begin
                p = (b == 0) ? -1 : sa / sb; r = p[31:0];
            end
            F3_DIVU: begin
                p = (b == 0) ? -1 : ua / ub; r = p[31:0];
            end
            F3_REM:  begin
                p = (b == 0) ? sa : sa % sb; r = p[31:0];
            end
            default: begin
                p = (b == 0) ? ua : ua % ub; r = p[31:0];
            end
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f3,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        bit sdiv;
        sdiv = (f3 == F3_DIV) || (f3 == F3_REM);
        if (f3[2] && b == 0) return 1;
        if (sdiv && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef FAST_MUL_EN
        if (!f3[2]) return 1;
`endif
        return 33;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input int exp_lat,
                          output int t_done);
        int stalls = 0;
        int lat = -1;
        logic [31:0] res = '0;
        t_done = 0;
        @(negedge clk);
        bus.Start = 1'b1; bus.Funct3 = f3;
        bus.SrcA = a; bus.SrcB = b;
        for (int c = 0; c < 80 && lat < 0; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (bus.Stall) stalls++;
            if (bus.Done) begin
                lat = c; res = bus.Result; t_done = cyc;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " stall"}, 32'(stalls), 32'(exp_lat));
        chk({tag, " result"}, res, exp_r);
    endtask

    task automatic idle_chk(input string tag, input logic [31:0] exp_r);
        @(negedge clk);
        bus.Start = 1'b0;
        #1;
        chk({tag, " idle stall"}, 32'(bus.Stall), 32'd0);
        chk({tag, " idle done"}, 32'(bus.Done), 32'd0);
        chk({tag, " held result"}, bus.Result, exp_r);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a, b, r;
        int          lat;
    } vec_t;

    vec_t dir[12];
    int   t0, t1, nd;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        dir[0]  = '{F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33};
        dir[1]  = '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        dir[2]  = '{F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        33};
        dir[3]  = '{F3_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
        dir[4]  = '{F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        dir[5]  = '{F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        dir[6]  = '{F3_DIVU,   32'd100,      32'd7,        32'd14,       33};
        dir[7]  = '{F3_REMU,   32'd100,      32'd7,        32'd2,        33};
        dir[8]  = '{F3_DIV,    32'd1234,     32'd0,        32'hFFFFFFFF, 1};
        dir[9]  = '{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        dir[10] = '{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        1};
        dir[11] = '{F3_REMU,   32'd55,       32'd0,        32'd55,       1};
`ifdef FAST_MUL_EN
        for (int i = 0; i < 4; i++) dir[i].lat = 1;
`endif

        rst_n = 1'b0;
        bus.Start = 1'b1; bus.Flush = 1'b0; bus.Funct3 = F3_MUL;
        bus.SrcA = 32'd3; bus.SrcB = 32'd3;
        #12;
        chk("reset stall", 32'(bus.Stall), 32'd0);
        chk("reset done", 32'(bus.Done), 32'd0);
        chk("reset result", bus.Result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; bus.Start = 1'b0;
        #1;
        chk("idle no start stall", 32'(bus.Stall), 32'd0);

        for (int i = 0; i < 12; i++) begin
            chk($sformatf("model dir%0d", i),
                ref_model(dir[i].f3, dir[i].a, dir[i].b), dir[i].r);
            run_op($sformatf("dir%0d", i), dir[i].f3, dir[i].a, dir[i].b,
                   dir[i].r, dir[i].lat, t0);
        end
        idle_chk("dir", dir[11].r);

        // Flush in the middle of a multiply
        @(negedge clk);
        bus.Start = 1'b1; bus.Funct3 = F3_MUL;
        bus.SrcA = 32'd5; bus.SrcB = 32'd6;
        repeat (10) @(negedge clk);
        bus.Flush = 1'b1;
        #1;
        chk("flush stall", 32'(bus.Stall), 32'd0);
        chk("flush done", 32'(bus.Done), 32'd0);
        @(negedge clk);
        bus.Flush = 1'b0; bus.Start = 1'b0;
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.Done || bus.Stall) nd++;
            @(negedge clk);
        end
        chk("flush quiet", 32'(nd), 32'd0);
        chk("flush result hold", bus.Result, dir[11].r);
        run_op("post flush mul", F3_MUL, 32'd3, 32'd4, 32'd12,
               ref_lat(F3_MUL, 32'd3, 32'd4), t0);

        // Reset in the middle of a multiply
        @(negedge clk);
        bus.Start = 1'b1; bus.Funct3 = F3_MUL;
        bus.SrcA = 32'd9; bus.SrcB = 32'd9;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset stall", 32'(bus.Stall), 32'd0);
        chk("midreset done", 32'(bus.Done), 32'd0);
        chk("midreset result", bus.Result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; bus.Start = 1'b0;
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.Done) nd++;
            @(negedge clk);
        end
        chk("midreset no done", 32'(nd), 32'd0);

        run_op("b2b first", F3_MUL, 32'd3, 32'd5, 32'd15,
               ref_lat(F3_MUL, 32'd3, 32'd5), t0);
        run_op("b2b second", F3_MUL, 32'd6, 32'd7, 32'd42,
               ref_lat(F3_MUL, 32'd6, 32'd7), t1);
        chk("b2b gap", 32'(t1 - t0), 32'(ref_lat(F3_MUL, 32'd6, 32'd7) + 1));
        idle_chk("b2b", 32'd42);

        for (int i = 0; i < 40; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = pick();
            rb  = pick();
            run_op($sformatf("rnd%0d f3=%0d a=%h b=%h", i, rf3, ra, rb),
                   rf3, ra, rb, ref_model(rf3, ra, rb),
                   ref_lat(rf3, ra, rb), t0);
        end
        idle_chk("rnd end", ref_model(rf3, ra, rb));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
